// File: rtl/distance_avg_bcd.sv
// Distance smoothing and BCD conversion for the ultrasonic ranging path.
// Captures each new 9-bit distance (cm), keeps a 2^AVG_LOG2 moving average,
// converts the average to three BCD digits with a serial double-dabble and
// raises a proximity alarm. Define DIST_HYST_EN to give the alarm a
// hysteresis band of HYST_CM above ALARM_CM.
module distance_avg_bcd #(
    parameter int AVG_LOG2      = 2,
    parameter int SAMPLE_PERIOD = 7_000_000,
    parameter int ALARM_CM      = 10,
    parameter int HYST_CM       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] distance,
    output logic [8:0] avg_distance,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       bcd_valid,
    output logic       busy,
    output logic       alarm
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SW    = 9 + AVG_LOG2;
    localparam int CW    = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(SAMPLE_PERIOD - 1);
`ifdef DIST_HYST_EN
    localparam int HYST_EFF = HYST_CM;
`else
    // Without hysteresis the clear threshold collapses onto the set threshold.
    localparam int HYST_EFF = 0 * HYST_CM;
`endif
    localparam logic [8:0] SET_CM   = 9'(ALARM_CM);
    localparam logic [8:0] CLEAR_CM = 9'(ALARM_CM + HYST_EFF);

    typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, DONE} state_t;

    state_t        state, next_state;
    logic [8:0]    last_distance;
    logic [8:0]    sample;
    logic [CW-1:0] period_cnt;
    logic          pending;
    logic          first;
    logic [8:0]    win [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [SW-1:0] sum;
    logic [SW-1:0] sum_next;
    logic [8:0]    avg_next;
    logic [3:0]    iter;
    logic [11:0]   bcd_sr;
    logic [8:0]    bin_sr;
    logic [20:0]   dd_adj;
    logic          sample_event;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    assign sample_event = (distance != last_distance) || (period_cnt == PERIOD_LAST);
    assign sum_next     = sum + SW'(sample) - SW'(win[wr_ptr]);
    assign avg_next     = first ? sample : 9'(sum_next >> AVG_LOG2);
    assign dd_adj       = {add3(bcd_sr[11:8]), add3(bcd_sr[7:4]), add3(bcd_sr[3:0]), bin_sr};

    // Track the previous input and the forced-sample period counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_distance <= '0;
            period_cnt    <= '0;
        end else begin
            last_distance <= distance;
            period_cnt    <= sample_event ? '0 : period_cnt + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_event || pending) next_state = ACCUM;
            ACCUM:   next_state = CONVERT;
            CONVERT: if (iter == 4'd8) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the sample when idle; remember one event that arrives while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample  <= '0;
            pending <= 1'b0;
        end else if (state == IDLE) begin
            if (sample_event || pending) begin
                sample  <= distance;
                pending <= 1'b0;
            end
        end else if (sample_event) begin
            pending <= 1'b1;
        end
    end

    // Moving-average window: preload on the first sample, else replace the oldest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wr_ptr       <= '0;
            sum          <= '0;
            first        <= 1'b1;
            avg_distance <= '0;
        end else if (state == ACCUM) begin
            if (first) begin
                for (int i = 0; i < DEPTH; i++) win[i] <= sample;
                sum   <= SW'(sample) << AVG_LOG2;
                first <= 1'b0;
            end else begin
                win[wr_ptr] <= sample;
                sum         <= sum_next;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            avg_distance <= avg_next;
        end
    end

    // Serial double-dabble, digit/alarm update and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter         <= '0;
            bcd_sr       <= '0;
            bin_sr       <= '0;
            bcd_hundreds <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
            bcd_valid    <= 1'b0;
            busy         <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    busy   <= 1'b1;
                    iter   <= '0;
                    bcd_sr <= '0;
                    bin_sr <= avg_next;
                end
                CONVERT: begin
                    {bcd_sr, bin_sr} <= {dd_adj[19:0], 1'b0};
                    iter             <= iter + 4'd1;
                end
                DONE: begin
                    bcd_hundreds <= bcd_sr[11:8];
                    bcd_tens     <= bcd_sr[7:4];
                    bcd_ones     <= bcd_sr[3:0];
                    bcd_valid    <= 1'b1;
                    busy         <= 1'b0;
                    if (avg_distance < SET_CM)
                        alarm <= 1'b1;
                    else if (avg_distance >= CLEAR_CM)
                        alarm <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_distance_avg_bcd.sv
// Randomized and directed bench for distance_avg_bcd with a queue-based
// moving-average reference model. Main instance uses a 4-deep window,
// a second instance uses a 1-deep window for the alarm checks.
module tb_distance_avg_bcd;

    localparam int SP    = 50;
    localparam int N     = 4;
    localparam int ALARM = 10;
    localparam int HYST  = 3;

    logic       clk;
    logic       reset, reset0;
    logic [8:0] distance, distance0;
    logic [8:0] avg_distance, avg_distance0;
    logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
    logic [3:0] bcd_hundreds0, bcd_tens0, bcd_ones0;
    logic       bcd_valid, busy, alarm;
    logic       bcd_valid0, busy0, alarm0;

    distance_avg_bcd #(.AVG_LOG2(2), .SAMPLE_PERIOD(SP), .ALARM_CM(ALARM), .HYST_CM(HYST)) dut (
        .clk(clk), .reset(reset), .distance(distance),
        .avg_distance(avg_distance), .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones), .bcd_valid(bcd_valid), .busy(busy), .alarm(alarm)
    );

    distance_avg_bcd #(.AVG_LOG2(0), .SAMPLE_PERIOD(SP), .ALARM_CM(ALARM), .HYST_CM(HYST)) dut0 (
        .clk(clk), .reset(reset0), .distance(distance0),
        .avg_distance(avg_distance0), .bcd_hundreds(bcd_hundreds0), .bcd_tens(bcd_tens0),
        .bcd_ones(bcd_ones0), .bcd_valid(bcd_valid0), .busy(busy0), .alarm(alarm0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int hist[$];
    bit m_first  = 1'b1;
    bit m_alarm  = 1'b0;
    bit m_alarm0 = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_avg(input int s);
        int total;
        if (m_first) begin
            hist.delete();
            for (int i = 0; i < N; i++) hist.push_back(s);
            m_first = 1'b0;
        end else begin
            hist.push_back(s);
            void'(hist.pop_front());
        end
        total = 0;
        foreach (hist[i]) total += hist[i];
        return total / N;
    endfunction

    function automatic bit next_alarm(input bit prev, input int avg);
`ifdef DIST_HYST_EN
        if (avg < ALARM) return 1'b1;
        if (avg >= ALARM + HYST) return 1'b0;
        return prev;
`else
        return (avg < ALARM) | (prev & 1'b0);
`endif
    endfunction

    task automatic do_reset();
        distance = '0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        hist.delete();
        m_first  = 1'b1;
        m_alarm  = 1'b0;
    endtask

    task automatic drive(input bit sel, input int v);
        @(negedge clk);
        if (sel) distance0 = 9'(v);
        else     distance  = 9'(v);
    endtask

    task automatic wait_valid(input bit sel, input int budget, output int k);
        k = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((sel ? bcd_valid0 : bcd_valid) == 1'b1) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input bit sel, input int e, input bit ea);
        check({tag, "_avg"},   sel ? int'(avg_distance0) : int'(avg_distance), e);
        check({tag, "_hund"},  sel ? int'(bcd_hundreds0) : int'(bcd_hundreds), e / 100);
        check({tag, "_tens"},  sel ? int'(bcd_tens0)     : int'(bcd_tens),     (e / 10) % 10);
        check({tag, "_ones"},  sel ? int'(bcd_ones0)     : int'(bcd_ones),     e % 10);
        check({tag, "_alarm"}, sel ? int'(alarm0)        : int'(alarm),        int'(ea));
        check({tag, "_busy"},  sel ? int'(busy0)         : int'(busy),         0);
    endtask

    task automatic expect_conv(input string tag, input bit sel, input int s,
                               input int exp_lat, input int budget);
        int e, k;
        if (sel) begin
            e = s;
            m_alarm0 = next_alarm(m_alarm0, e);
        end else begin
            e = model_avg(s);
            m_alarm = next_alarm(m_alarm, e);
        end
        wait_valid(sel, budget, k);
        check({tag, "_seen"}, int'(k != 0), 1);
        if (k == 0) return;
        if (exp_lat != 0) check({tag, "_lat"}, k, exp_lat);
        check_outputs(tag, sel, e, sel ? m_alarm0 : m_alarm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, e, v, cnt;
        reset = 1'b1; reset0 = 1'b1; distance = '0; distance0 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_avg",   int'(avg_distance), 0);
        check("rst_digits", int'({bcd_hundreds, bcd_tens, bcd_ones}), 0);
        check("rst_flags", int'({bcd_valid, busy, alarm}), 0);

        // first sample preloads the window, latency check on avg and bcd_valid
        drive(0, 123);
        e = model_avg(123);
        m_alarm = next_alarm(m_alarm, e);
        repeat (2) @(negedge clk);
        check("first_avg_t2", int'(avg_distance), 123);
        check("first_busy",   int'(busy), 1);
        wait_valid(0, 20, k);
        check("first_seen", int'(k != 0), 1);
        check("first_lat",  k + 2, 12);
        check_outputs("first", 0, e, m_alarm);

        // preload 100, three forced samples of 100, then 20 -> 80
        do_reset();
        drive(0, 100);
        expect_conv("p100", 0, 100, 12, 20);
        for (int i = 0; i < 3; i++) expect_conv("f100", 0, 100, SP, SP + 20);
        repeat (3) @(negedge clk);
        drive(0, 20);
        expect_conv("s20", 0, 20, 12, 20);

        // maximum input held: forced samples, no overflow
        do_reset();
        drive(0, 511);
        expect_conv("p511", 0, 511, 12, 20);
        for (int i = 0; i < 3; i++) expect_conv("f511", 0, 511, SP, SP + 20);

        // two changes during a conversion collapse into one pending sample
        do_reset();
        drive(0, 200);
        e = model_avg(200);
        m_alarm = next_alarm(m_alarm, e);
        repeat (4) @(negedge clk);
        distance = 9'd30;
        repeat (2) @(negedge clk);
        distance = 9'd40;
        wait_valid(0, 20, k);
        check("pend1_seen", int'(k != 0), 1);
        check("pend1_lat",  k + 6, 12);
        check_outputs("pend1", 0, e, m_alarm);
        expect_conv("pend2", 0, 40, 12, 20);
        wait_valid(0, 25, k);
        check("pend_no_third", k, 0);

        // randomized distinct samples, each producing one conversion
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do v = int'($urandom_range(0, 511)); while (v == int'(distance));
            repeat ($urandom_range(0, 15)) @(negedge clk);
            drive(0, v);
            expect_conv("rnd", 0, v, 12, 20);
        end

        // reset during conversion aborts it and re-arms the preload
        do_reset();
        drive(0, 77);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        distance = '0;
        #1;
        check("midrst_avg",   int'(avg_distance), 0);
        check("midrst_outs",  int'({bcd_hundreds, bcd_tens, bcd_ones, bcd_valid, busy, alarm}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hist.delete(); m_first = 1'b1; m_alarm = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bcd_valid) cnt++;
        end
        check("midrst_no_valid", cnt, 0);
        drive(0, 60);
        expect_conv("rst60", 0, 60, 12, 20);
        drive(0, 20);
        expect_conv("rst20", 0, 20, 12, 20);

        // one-deep window: alarm thresholds
        distance0 = '0;
        @(negedge clk);
        reset0 = 1'b0;
        drive(1, 15); expect_conv("a15", 1, 15, 12, 20);
        drive(1, 9);  expect_conv("a9",  1, 9,  12, 20);
        drive(1, 11); expect_conv("a11", 1, 11, 12, 20);
        drive(1, 13); expect_conv("a13", 1, 13, 12, 20);
        drive(1, 0);  expect_conv("a0",  1, 0,  12, 20);
        drive(1, 10); expect_conv("a10", 1, 10, 12, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/distance_avg_bcd.md
Name: distance_avg_bcd

Overview:
- Downstream consumer of the HC-SR04 ranging block's 9-bit distance (cm) output.
- Captures each new measurement and smooths it with a power-of-two moving average.
- Converts the average to three BCD digits with a sequential double-dabble engine, for the FND display path.
- Raises a proximity alarm when the averaged distance falls below a threshold.

Parameters:
- AVG_LOG2, 2, log2 of the averaging window depth (window = 4 samples); legal range 0..4.
- SAMPLE_PERIOD, 7_000_000, clk cycles between forced samples when the input is unchanged (70 ms at 100 MHz).
- ALARM_CM, 10, alarm threshold in cm.
- HYST_CM, 3, hysteresis in cm; used only with DIST_HYST_EN.

Ports:
- clk  input  1  system clock, 100 MHz, posedge.
- reset  input  1  asynchronous, active-high.
- distance  input  9  measured distance in cm, from the ranging block; changes at most once per measurement.
- avg_distance  output  9  current moving average in cm.
- bcd_hundreds  output  4  BCD hundreds digit of avg_distance (0..5).
- bcd_tens  output  4  BCD tens digit.
- bcd_ones  output  4  BCD ones digit.
- bcd_valid  output  1  one-clk pulse when the BCD outputs and alarm update.
- busy  output  1  high while a conversion is in progress.
- alarm  output  1  proximity alarm.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset. All state is updated on posedge clk.
- Reset values: all outputs are 0, state is IDLE, the window buffer and running sum are 0, the first-sample flag is set, and the period counter and pending flag are 0.
- Sample event (evaluated every cycle):
  - distance differs from last_distance (a registered copy of distance), or
  - the period counter reaches SAMPLE_PERIOD-1.
  - The period counter clears on every sample event, whether the event is processed at once or latched as pending.
- FSM states: IDLE, ACCUM, CONVERT, DONE.
- IDLE:
  - Moves to ACCUM on a sample event or when pending=1.
  - Captures distance into the sample register and clears pending.
- ACCUM (1 cycle):
  - First sample after reset: every window entry is preloaded with the sample, sum = sample<<AVG_LOG2, and the first-sample flag clears.
  - Otherwise: sum <= sum + sample - buf[wr_ptr], then buf[wr_ptr] <= sample, then wr_ptr increments and wraps modulo 2^AVG_LOG2.
  - sum width is 9+AVG_LOG2 bits and cannot overflow. avg_distance is sum>>AVG_LOG2 (truncating), registered on exit from ACCUM.
  - busy is set on exit from ACCUM.
- CONVERT:
  - Double-dabble over the 9 bits of avg_distance.
  - One shift per cycle, 9 cycles; add-3 is applied to any digit >=5 before each shift.
  - A 4-bit iteration counter runs 0..8.
- DONE (1 cycle):
  - Loads bcd_hundreds, bcd_tens and bcd_ones.
  - Updates alarm.
  - Pulses bcd_valid.
  - Clears busy and returns to IDLE.
- Latency: a sample event at cycle t gives avg_distance valid at t+2 and bcd_valid at t+12.
- Event while not IDLE: sets pending (one deep). Multiple events collapse into one. distance is re-sampled when pending is serviced, so the newest value is used.
- Alarm, base behaviour: alarm = (avg_distance < ALARM_CM), evaluated in DONE only. A value of 0 counts as below the threshold.
- Reset mid-conversion: all state is cleared immediately. No bcd_valid pulse is issued.

Optional Feature:
- Macro DIST_HYST_EN.
- Defined:
  - alarm sets when avg < ALARM_CM.
  - alarm clears only when avg >= ALARM_CM+HYST_CM.
  - alarm otherwise holds.
- Undefined: plain compare as described in Behaviour; HYST_CM is unused.

Test Plan:
- Reset, then distance=123 -> bcd_valid at t+12 with avg=123, digits 1/2/3, alarm=0.
- After the preload at 100, apply samples 100,100,100,20 -> final avg=80, digits 0/8/0.
- distance=511 held, no changes -> forced samples every SAMPLE_PERIOD (set to 50 for sim), each giving digits 5/1/1 with no overflow.
- Change distance twice during CONVERT (30 then 40) -> exactly one extra conversion, using 40.
- AVG_LOG2=0, distance 15 then 9 -> alarm 0 then 1.
  - With DIST_HYST_EN: 11 keeps alarm=1, 13 clears it.
- Assert reset during CONVERT -> outputs 0 and no bcd_valid. The next sample preloads the window.
